// File: rtl/bsg_manycore_link_to_cce_arb_pkg.sv
// bsg_manycore_link_to_cce_arb_pkg: shared FSM encoding and default widths for the CCE link arbiter
package bsg_manycore_link_to_cce_arb_pkg;

    typedef enum logic {ST_IDLE, ST_HOLD} arb_state_e;

    localparam int default_mem_cmd_width_lp       = 64;
    localparam int default_mem_data_resp_width_lp = 64;

endpackage

// File: rtl/bsg_manycore_link_to_cce_arb_tag_fifo.sv
// bsg_fifo_1r1w_small: small circular FIFO that remembers which requester owns each outstanding command
module bsg_fifo_1r1w_small #(
    parameter int width_p = 1,
    parameter int els_p   = 2
) (
    input  logic                       clk_i,
    input  logic                       reset_n_i,
    input  logic                       v_i,
    output logic                       ready_o,
    input  logic [width_p-1:0]         data_i,
    output logic                       v_o,
    output logic [width_p-1:0]         data_o,
    input  logic                       yumi_i,
    output logic [$clog2(els_p+1)-1:0] count_o
);
    localparam int ptr_w_lp = els_p > 1 ? $clog2(els_p) : 1;
    localparam int cnt_w_lp = $clog2(els_p + 1);

    logic [width_p-1:0]  mem_q [els_p];
    logic [width_p-1:0]  mem_d [els_p];
    logic [ptr_w_lp-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [cnt_w_lp-1:0] cnt_q, cnt_d;
    logic                push, pop;

    assign v_o     = cnt_q != '0;
    assign ready_o = cnt_q != cnt_w_lp'(els_p) || yumi_i;
    assign data_o  = mem_q[rd_q];
    assign count_o = cnt_q;
    assign push    = v_i && ready_o;
    assign pop     = yumi_i && v_o;

    // Pointer and occupancy update; a push while full is legal only alongside a pop.
    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        if (push) begin
            mem_d[wr_q] = data_i;
            wr_d        = wr_q == ptr_w_lp'(els_p - 1) ? '0 : wr_q + 1'b1;
        end
        if (pop) rd_d = rd_q == ptr_w_lp'(els_p - 1) ? '0 : rd_q + 1'b1;
        cnt_d = cnt_q + cnt_w_lp'(push) - cnt_w_lp'(pop);
    end

    // Storage is not reset; only the pointers and count are.
    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
        if (!reset_n_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/bsg_manycore_link_to_cce_arb.sv
// bsg_manycore_link_to_cce_arb: round-robin funnel of CCE mem commands onto one link converter with in-order response return
module bsg_manycore_link_to_cce_arb
    import bsg_manycore_link_to_cce_arb_pkg::*;
#(
    parameter int num_req_p             = 2,
    parameter int mem_cmd_width_p       = default_mem_cmd_width_lp,
    parameter int mem_data_resp_width_p = default_mem_data_resp_width_lp,
    parameter int max_outstanding_p     = 4
) (
    input  logic                                       clk_i,
    input  logic                                       reset_n_i,
    input  logic [num_req_p-1:0][mem_cmd_width_p-1:0]  mem_cmd_i,
    input  logic [num_req_p-1:0]                       mem_cmd_v_i,
    output logic [num_req_p-1:0]                       mem_cmd_ready_o,
    output logic [mem_data_resp_width_p-1:0]           mem_data_resp_o,
    output logic [num_req_p-1:0]                       mem_data_resp_v_o,
    input  logic [num_req_p-1:0]                       mem_data_resp_ready_i,
    output logic [mem_cmd_width_p-1:0]                 link_mem_cmd_o,
    output logic                                       link_mem_cmd_v_o,
    input  logic                                       link_mem_cmd_ready_i,
    input  logic [mem_data_resp_width_p-1:0]           link_mem_data_resp_i,
    input  logic                                       link_mem_data_resp_v_i,
    output logic                                       link_mem_data_resp_ready_o
);
    localparam int tag_w_lp = $clog2(num_req_p);
    localparam int cnt_w_lp = $clog2(max_outstanding_p + 1);

    arb_state_e            state_q, state_d;
    logic [tag_w_lp-1:0]   rr_q, rr_d, hi_idx, lo_idx, grant_idx, head_tag;
    logic [mem_cmd_width_p-1:0] cmd_q, cmd_d;
    logic                  hi_v, lo_v, grant_v, full, push, pop, tag_v, tag_ready;
    logic [cnt_w_lp-1:0]   outstanding;

    // Round-robin pick: lowest valid index at or above the pointer, else lowest below it.
    always_comb begin
        hi_v   = 1'b0;
        lo_v   = 1'b0;
        hi_idx = '0;
        lo_idx = '0;
        for (int i = num_req_p - 1; i >= 0; i--) begin
            if (mem_cmd_v_i[i] && i >= int'(rr_q)) begin
                hi_v   = 1'b1;
                hi_idx = tag_w_lp'(i);
            end
            if (mem_cmd_v_i[i] && i < int'(rr_q)) begin
                lo_v   = 1'b1;
                lo_idx = tag_w_lp'(i);
            end
        end
        grant_idx = hi_v ? hi_idx : lo_idx;
    end

    assign full = outstanding == cnt_w_lp'(max_outstanding_p);

    // IDLE grants and latches a command, HOLD presents it until the converter takes it.
    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        cmd_d   = cmd_q;
        grant_v = 1'b0;
        if (state_q == ST_IDLE) begin
            grant_v = reset_n_i && (hi_v || lo_v) && !full;
            if (grant_v) begin
                state_d = ST_HOLD;
                cmd_d   = mem_cmd_i[grant_idx];
                rr_d    = grant_idx == tag_w_lp'(num_req_p - 1) ? '0 : grant_idx + 1'b1;
            end
        end else if (link_mem_cmd_ready_i) begin
            state_d = ST_IDLE;
        end
    end

    // FSM, priority pointer and held command registers.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q <= ST_IDLE;
            rr_q    <= '0;
            cmd_q   <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            cmd_q   <= cmd_d;
        end
    end

    assign mem_cmd_ready_o  = grant_v ? num_req_p'(1) << grant_idx : '0;
    assign link_mem_cmd_v_o = reset_n_i && state_q == ST_HOLD;
    assign link_mem_cmd_o   = reset_n_i ? cmd_q : '0;
    assign push             = link_mem_cmd_v_o && link_mem_cmd_ready_i;

    bsg_fifo_1r1w_small #(
        .width_p(tag_w_lp),
        .els_p  (max_outstanding_p)
    ) tag_fifo (
        .clk_i    (clk_i),
        .reset_n_i(reset_n_i),
        .v_i      (push),
        .ready_o  (tag_ready),
        .data_i   (state_q == ST_HOLD ? rr_q - 1'b1 : '0),
        .v_o      (tag_v),
        .data_o   (head_tag),
        .yumi_i   (pop),
        .count_o  (outstanding)
    );

    // Responses go to the requester whose command is oldest outstanding.
    always_comb begin
        mem_data_resp_v_o = '0;
        for (int i = 0; i < num_req_p; i++)
            mem_data_resp_v_o[i] = link_mem_data_resp_v_i && tag_v && head_tag == tag_w_lp'(i);
    end

    assign mem_data_resp_o            = link_mem_data_resp_i;
    assign link_mem_data_resp_ready_o = tag_v && mem_data_resp_ready_i[head_tag];
    assign pop                        = link_mem_data_resp_ready_o && link_mem_data_resp_v_i;

    // A response with nothing outstanding, or a push into a full tag FIFO, is a protocol error.
    always_ff @(posedge clk_i) begin
        if (reset_n_i) begin
            assert (!(link_mem_data_resp_v_i && !tag_v));
            assert (!push || tag_ready);
            assert (outstanding <= cnt_w_lp'(max_outstanding_p));
        end
    end

endmodule

// File: tb/tb_bsg_manycore_link_to_cce_arb.sv
// tb_bsg_manycore_link_to_cce_arb: vector table plus directed sequences for the CCE link arbiter
module tb_bsg_manycore_link_to_cce_arb;

    typedef struct {
        logic        rst_n;
        logic [1:0]  v;
        logic [15:0] c0;
        logic [15:0] c1;
        logic        lcr;
        logic        lrv;
        logic [15:0] lr;
        logic [1:0]  rr;
        logic [1:0]  e_rdy;
        logic        e_lcv;
        logic [15:0] e_lcmd;
        logic [1:0]  e_rv;
        logic        e_lrr;
    } vec_t;

    logic             clk_i = 1'b0;
    logic             reset_n_i;
    logic [1:0][15:0] mem_cmd_i;
    logic [1:0]       mem_cmd_v_i;
    logic [1:0]       mem_cmd_ready_o;
    logic [15:0]      mem_data_resp_o;
    logic [1:0]       mem_data_resp_v_o;
    logic [1:0]       mem_data_resp_ready_i;
    logic [15:0]      link_mem_cmd_o;
    logic             link_mem_cmd_v_o;
    logic             link_mem_cmd_ready_i;
    logic [15:0]      link_mem_data_resp_i;
    logic             link_mem_data_resp_v_i;
    logic             link_mem_data_resp_ready_o;

    int tests = 0;
    int failed = 0;
    vec_t tbl [20];

    bsg_manycore_link_to_cce_arb #(
        .num_req_p(2),
        .mem_cmd_width_p(16),
        .mem_data_resp_width_p(16),
        .max_outstanding_p(4)
    ) dut (
        .clk_i(clk_i),
        .reset_n_i(reset_n_i),
        .mem_cmd_i(mem_cmd_i),
        .mem_cmd_v_i(mem_cmd_v_i),
        .mem_cmd_ready_o(mem_cmd_ready_o),
        .mem_data_resp_o(mem_data_resp_o),
        .mem_data_resp_v_o(mem_data_resp_v_o),
        .mem_data_resp_ready_i(mem_data_resp_ready_i),
        .link_mem_cmd_o(link_mem_cmd_o),
        .link_mem_cmd_v_o(link_mem_cmd_v_o),
        .link_mem_cmd_ready_i(link_mem_cmd_ready_i),
        .link_mem_data_resp_i(link_mem_data_resp_i),
        .link_mem_data_resp_v_i(link_mem_data_resp_v_i),
        .link_mem_data_resp_ready_o(link_mem_data_resp_ready_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic set_in(input logic rst_n, input logic [1:0] v, input logic [15:0] c0, input logic [15:0] c1,
                          input logic lcr, input logic lrv, input logic [15:0] lr, input logic [1:0] rr);
        reset_n_i              = rst_n;
        mem_cmd_v_i            = v;
        mem_cmd_i[0]           = c0;
        mem_cmd_i[1]           = c1;
        link_mem_cmd_ready_i   = lcr;
        link_mem_data_resp_v_i = lrv;
        link_mem_data_resp_i   = lr;
        mem_data_resp_ready_i  = rr;
    endtask

    task automatic tick();
        @(negedge clk_i);
    endtask

    task automatic do_reset(input string nm);
        set_in(1'b0, 2'b00, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 2'b00);
        repeat (3) tick();
        #1;
        chk({nm, " rst cmd_ready"}, 64'(mem_cmd_ready_o), 64'h0);
        chk({nm, " rst link_v"}, 64'(link_mem_cmd_v_o), 64'h0);
        chk({nm, " rst resp_v"}, 64'(mem_data_resp_v_o), 64'h0);
        chk({nm, " rst link_resp_ready"}, 64'(link_mem_data_resp_ready_o), 64'h0);
        reset_n_i = 1'b1;
        #1;
        chk({nm, " post-rst link_v"}, 64'(link_mem_cmd_v_o), 64'h0);
        chk({nm, " post-rst link_cmd"}, 64'(link_mem_cmd_o), 64'h0);
        tick();
    endtask

    initial begin
        tbl[0]  = '{1'b0, 2'b11, 16'hA000, 16'hB000, 1'b1, 1'b0, 16'h0000, 2'b11, 2'b00, 1'b0, 16'h0000, 2'b00, 1'b0};
        tbl[1]  = '{1'b1, 2'b00, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0000, 2'b00, 2'b00, 1'b0, 16'h0000, 2'b00, 1'b0};
        tbl[2]  = '{1'b1, 2'b10, 16'hA001, 16'hB001, 1'b0, 1'b0, 16'h0000, 2'b00, 2'b10, 1'b0, 16'h0000, 2'b00, 1'b0};
        tbl[3]  = '{1'b1, 2'b11, 16'hA002, 16'hB002, 1'b0, 1'b0, 16'h0000, 2'b00, 2'b00, 1'b1, 16'hB001, 2'b00, 1'b0};
        tbl[4]  = '{1'b1, 2'b11, 16'hA003, 16'hB003, 1'b1, 1'b0, 16'h0000, 2'b00, 2'b00, 1'b1, 16'hB001, 2'b00, 1'b0};
        tbl[5]  = '{1'b1, 2'b01, 16'hA005, 16'hB005, 1'b1, 1'b0, 16'h0000, 2'b00, 2'b01, 1'b0, 16'hB001, 2'b00, 1'b0};
        tbl[6]  = '{1'b1, 2'b00, 16'h0000, 16'h0000, 1'b1, 1'b1, 16'hD001, 2'b11, 2'b00, 1'b1, 16'hA005, 2'b10, 1'b1};
        tbl[7]  = '{1'b1, 2'b00, 16'h0000, 16'h0000, 1'b1, 1'b1, 16'hD002, 2'b01, 2'b00, 1'b0, 16'hA005, 2'b01, 1'b1};
        tbl[8]  = '{1'b1, 2'b11, 16'hA008, 16'hB008, 1'b0, 1'b0, 16'h0000, 2'b00, 2'b10, 1'b0, 16'hA005, 2'b00, 1'b0};
        tbl[9]  = '{1'b1, 2'b11, 16'hA009, 16'hB009, 1'b1, 1'b0, 16'h0000, 2'b00, 2'b00, 1'b1, 16'hB008, 2'b00, 1'b0};
        tbl[10] = '{1'b1, 2'b00, 16'h0000, 16'h0000, 1'b1, 1'b1, 16'hD003, 2'b01, 2'b00, 1'b0, 16'hB008, 2'b10, 1'b0};
        tbl[11] = '{1'b1, 2'b00, 16'h0000, 16'h0000, 1'b1, 1'b1, 16'hD004, 2'b01, 2'b00, 1'b0, 16'hB008, 2'b10, 1'b0};
        tbl[12] = '{1'b1, 2'b00, 16'h0000, 16'h0000, 1'b1, 1'b1, 16'hD005, 2'b10, 2'b00, 1'b0, 16'hB008, 2'b10, 1'b1};
        tbl[13] = '{1'b1, 2'b00, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0000, 2'b11, 2'b00, 1'b0, 16'hB008, 2'b00, 1'b0};
        tbl[14] = '{1'b1, 2'b01, 16'hA00E, 16'hB00E, 1'b0, 1'b0, 16'h0000, 2'b00, 2'b01, 1'b0, 16'hB008, 2'b00, 1'b0};
        tbl[15] = '{1'b1, 2'b00, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 2'b00, 2'b00, 1'b1, 16'hA00E, 2'b00, 1'b0};
        tbl[16] = '{1'b0, 2'b00, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 2'b00, 2'b00, 1'b0, 16'h0000, 2'b00, 1'b0};
        tbl[17] = '{1'b1, 2'b11, 16'hA011, 16'hB011, 1'b0, 1'b0, 16'h0000, 2'b00, 2'b01, 1'b0, 16'h0000, 2'b00, 1'b0};
        tbl[18] = '{1'b1, 2'b00, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0000, 2'b00, 2'b00, 1'b1, 16'hA011, 2'b00, 1'b0};
        tbl[19] = '{1'b1, 2'b00, 16'h0000, 16'h0000, 1'b1, 1'b1, 16'hD006, 2'b11, 2'b00, 1'b0, 16'hA011, 2'b01, 1'b1};

        do_reset("init");

        for (int i = 0; i < 20; i++) begin
            set_in(tbl[i].rst_n, tbl[i].v, tbl[i].c0, tbl[i].c1, tbl[i].lcr, tbl[i].lrv, tbl[i].lr, tbl[i].rr);
            #1;
            chk($sformatf("vec%0d cmd_ready", i), 64'(mem_cmd_ready_o), 64'(tbl[i].e_rdy));
            chk($sformatf("vec%0d link_v", i), 64'(link_mem_cmd_v_o), 64'(tbl[i].e_lcv));
            chk($sformatf("vec%0d link_cmd", i), 64'(link_mem_cmd_o), 64'(tbl[i].e_lcmd));
            chk($sformatf("vec%0d resp_v", i), 64'(mem_data_resp_v_o), 64'(tbl[i].e_rv));
            chk($sformatf("vec%0d link_resp_ready", i), 64'(link_mem_data_resp_ready_o), 64'(tbl[i].e_lrr));
            chk($sformatf("vec%0d resp_data", i), 64'(mem_data_resp_o), 64'(tbl[i].lr));
            tick();
        end

        do_reset("fair");
        for (int k = 0; k < 8; k++) begin
            set_in(1'b1, 2'b11, 16'hC000 + 16'(k), 16'hC100 + 16'(k), 1'b1, k > 0, 16'hE000 + 16'(k), 2'b11);
            #1;
            chk($sformatf("fair%0d grant", k), 64'(mem_cmd_ready_o), (k % 2) ? 64'h2 : 64'h1);
            if (k > 0) chk($sformatf("fair%0d resp_v", k), 64'(mem_data_resp_v_o), (k % 2) ? 64'h1 : 64'h2);
            tick();
            link_mem_data_resp_v_i = 1'b0;
            #1;
            chk($sformatf("fair%0d link_v", k), 64'(link_mem_cmd_v_o), 64'h1);
            chk($sformatf("fair%0d link_cmd", k), 64'(link_mem_cmd_o), (k % 2) ? 64'hC100 + 64'(k) : 64'hC000 + 64'(k));
            tick();
        end
        set_in(1'b1, 2'b00, 16'h0, 16'h0, 1'b1, 1'b1, 16'hE0FF, 2'b11);
        #1;
        chk("fair last resp_v", 64'(mem_data_resp_v_o), 64'h2);
        tick();

        set_in(1'b1, 2'b11, 16'hF000, 16'hF100, 1'b0, 1'b0, 16'h0, 2'b11);
        #1;
        chk("bp grant", 64'(mem_cmd_ready_o), 64'h1);
        tick();
        for (int j = 0; j < 5; j++) begin
            mem_cmd_i[0] = 16'hF001 + 16'(j);
            mem_cmd_i[1] = 16'hF101 + 16'(j);
            #1;
            chk($sformatf("bp%0d link_v", j), 64'(link_mem_cmd_v_o), 64'h1);
            chk($sformatf("bp%0d link_cmd", j), 64'(link_mem_cmd_o), 64'hF000);
            chk($sformatf("bp%0d cmd_ready", j), 64'(mem_cmd_ready_o), 64'h0);
            tick();
        end
        link_mem_cmd_ready_i = 1'b1;
        #1;
        chk("bp accept link_cmd", 64'(link_mem_cmd_o), 64'hF000);
        tick();
        set_in(1'b1, 2'b00, 16'h0, 16'h0, 1'b1, 1'b1, 16'hE100, 2'b11);
        #1;
        chk("bp resp_v", 64'(mem_data_resp_v_o), 64'h1);
        tick();

        for (int k = 0; k < 4; k++) begin
            set_in(1'b1, 2'b01, 16'h9000 + 16'(k), 16'h0, 1'b1, 1'b0, 16'h0, 2'b00);
            #1;
            chk($sformatf("full%0d grant", k), 64'(mem_cmd_ready_o), 64'h1);
            tick();
            #1;
            chk($sformatf("full%0d link_v", k), 64'(link_mem_cmd_v_o), 64'h1);
            tick();
        end
        for (int j = 0; j < 3; j++) begin
            #1;
            chk($sformatf("full stall%0d cmd_ready", j), 64'(mem_cmd_ready_o), 64'h0);
            chk($sformatf("full stall%0d link_v", j), 64'(link_mem_cmd_v_o), 64'h0);
            tick();
        end
        link_mem_data_resp_v_i = 1'b1;
        link_mem_data_resp_i   = 16'hE200;
        mem_data_resp_ready_i  = 2'b01;
        #1;
        chk("full pop resp_v", 64'(mem_data_resp_v_o), 64'h1);
        chk("full pop link_resp_ready", 64'(link_mem_data_resp_ready_o), 64'h1);
        chk("full pop cmd_ready", 64'(mem_cmd_ready_o), 64'h0);
        tick();
        link_mem_data_resp_v_i = 1'b0;
        #1;
        chk("full regrant", 64'(mem_cmd_ready_o), 64'h1);
        tick();
        mem_cmd_v_i = 2'b00;
        #1;
        chk("full regrant link_v", 64'(link_mem_cmd_v_o), 64'h1);
        tick();
        for (int j = 0; j < 4; j++) begin
            link_mem_data_resp_v_i = 1'b1;
            #1;
            chk($sformatf("drain%0d link_resp_ready", j), 64'(link_mem_data_resp_ready_o), 64'h1);
            tick();
        end
        link_mem_data_resp_v_i = 1'b0;
        #1;
        chk("drained link_resp_ready", 64'(link_mem_data_resp_ready_o), 64'h0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
